// File: rtl/uart_aes_pkg.sv
// uart_aes_pkg: shared constants and FSM state type for the UART/AES command sequencer
package uart_aes_pkg;

    localparam int NBYTES = 16;

    localparam logic [7:0] CMD_KEY  = 8'h01;
    localparam logic [7:0] CMD_ENC  = 8'h02;
    localparam logic [7:0] ACK_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_PT,
        AES_RUN,
        TX_SEND,
        TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_aes_sequencer_timeout.sv
// timeout_counter: counts idle cycles between received bytes and flags the cycle that reaches the limit
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    // expire fires on the edge that would bring the count to TIMEOUT_CYCLES-1; a byte in the same cycle wins
    assign expire = enable && !clear && count == W'(TIMEOUT_CYCLES - 2);

    // idle-cycle counter, restarted by every byte and whenever the FSM is not receiving
    always_ff @(posedge clk) begin
        if (!reset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_aes_sequencer.sv
// uart_aes_sequencer: parses host commands, assembles key/plaintext blocks, runs the AES core and streams replies
module uart_aes_sequencer
    import uart_aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done,
    output logic [8*NBYTES-1:0] aes_key,
    output logic [8*NBYTES-1:0] aes_pt,
    output logic                aes_start,
    input  logic [8*NBYTES-1:0] aes_ct,
    input  logic                aes_done,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_overrun
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t              state;
    logic [CW-1:0]       byte_cnt;
    logic [8*NBYTES-1:0] ct_buf;
    logic                ack_reply;
    logic                receiving;
    logic                expire;

    assign receiving = state == RX_KEY || state == RX_PT;
    assign busy      = state != IDLE;

    timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (rx_done || !receiving),
        .enable(receiving),
        .expire(expire)
    );

    // command FSM with registered pulses; the ct buffer shifts left so its top byte is always the next to send
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            ct_buf      <= '0;
            ack_reply   <= 1'b0;
            aes_key     <= '0;
            aes_pt      <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            aes_start   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            aes_start   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= rx_done && (state == AES_RUN || state == TX_SEND || state == TX_WAIT);
            case (state)
                IDLE: begin
                    if (rx_done) begin
                        byte_cnt <= '0;
                        state    <= rx_data == CMD_KEY ? RX_KEY :
                                    rx_data == CMD_ENC ? RX_PT  : IDLE;
                    end
                end
                RX_KEY, RX_PT: begin
                    if (rx_done) begin
                        if (state == RX_KEY)
                            aes_key <= {aes_key[8*NBYTES-9:0], rx_data};
                        else
                            aes_pt <= {aes_pt[8*NBYTES-9:0], rx_data};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST) begin
                            ack_reply <= state == RX_KEY;
                            aes_start <= state == RX_PT;
                            state     <= state == RX_KEY ? TX_SEND : AES_RUN;
                        end
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                AES_RUN: begin
                    if (aes_done) begin
                        ct_buf   <= aes_ct;
                        byte_cnt <= '0;
                        state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    tx_start <= 1'b1;
                    tx_data  <= ack_reply ? ACK_BYTE : ct_buf[8*NBYTES-1 -: 8];
                    state    <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (ack_reply || byte_cnt == LAST) begin
                            state <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            ct_buf   <= ct_buf << 8;
                            state    <= TX_SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
